// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: in-order instruction fetch stage feeding the decoder.
// Issues 32-bit fetches under a credit limit, buffers the returned words in a
// small queue and hands {pc, inst, excp} to decode with a valid/ready handshake.
// A redirect flushes the queue and drops every response still outstanding.
// Optional feature macro: IFU_MISALIGN_EXC_EN. When it is defined, a misaligned
// redirect target produces one exception entry and fetch halts until the next
// redirect. When it is undefined, redirect targets are forced to word alignment.
module inst_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          IQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        br_e,
    input  logic [63:0] br_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc,
    output logic        id_excp
);
    localparam int AW = $clog2(IQ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(IQ_DEPTH);

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   resp_pc_q, resp_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [63:0]   q_pc   [IQ_DEPTH];
    logic [31:0]   q_inst [IQ_DEPTH];

    logic          credit_ok;
    logic          accept;
    logic          resp_ok;
    logic          resp_keep;
    logic          pop;
    logic          push;
    logic          halted;
    logic [63:0]   target_eff;
    logic [63:0]   push_pc;
    logic [31:0]   push_inst;

    // Outstanding requests plus buffered entries never exceed the queue size,
    // so every accepted request already owns a slot.
    assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_W;
    assign imem_req  = !rst && !br_e && credit_ok && !halted;
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;
    // A response with nothing in flight is a protocol violation and is ignored.
    assign resp_ok   = imem_rvalid && (inflight_q != '0);
    assign resp_keep = resp_ok && (discard_q == '0) && !br_e && !halted;
    assign id_valid  = (count_q != '0);
    // A dequeue in the redirect cycle is void; the consumer flushes on br_e too.
    assign pop       = id_valid && id_ready && !br_e;

`ifdef IFU_MISALIGN_EXC_EN
    logic        halted_q;
    logic        exc_pend_q;
    logic [63:0] exc_pc_q;
    logic        exc_push;
    logic [IQ_DEPTH-1:0] q_excp_q;

    assign target_eff = br_target;
    assign halted     = halted_q;
    // The exception entry waits until every flushed request has come back.
    assign exc_push   = exc_pend_q && (discard_q == '0) && !br_e;
    assign push       = resp_keep || exc_push;
    assign push_pc    = exc_push ? exc_pc_q : resp_pc_q;
    assign push_inst  = exc_push ? 32'h0 : imem_rdata;
    assign id_excp    = id_valid ? q_excp_q[rd_ptr_q] : 1'b0;

    // Halt and pending-exception tracking for misaligned redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q   <= 1'b0;
            exc_pend_q <= 1'b0;
            exc_pc_q   <= '0;
        end else if (br_e) begin
            halted_q   <= |br_target[1:0];
            exc_pend_q <= |br_target[1:0];
            exc_pc_q   <= br_target;
        end else if (exc_push) begin
            exc_pend_q <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_excp
        // Exception flag storage for queue entry gi
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == AW'(gi))) begin
                q_excp_q[gi] <= exc_push;
            end
        end
    end
`else
    assign target_eff = br_target & ~64'd3;
    assign halted     = 1'b0;
    assign push       = resp_keep;
    assign push_pc    = resp_pc_q;
    assign push_inst  = imem_rdata;
    assign id_excp    = 1'b0;
`endif

    assign id_inst = id_valid ? q_inst[rd_ptr_q] : 32'h0;
    assign id_pc   = id_valid ? q_pc[rd_ptr_q]   : 64'h0;

    // Next-state for PCs, queue pointers and the in-flight/discard counters
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q + CW'(accept) - CW'(resp_ok);
        discard_d  = discard_q;
        if (br_e) begin
            fetch_pc_d = target_eff;
            resp_pc_d  = target_eff;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            // Everything still outstanding after this cycle is stale.
            discard_d  = inflight_d;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            if (resp_keep) begin
                resp_pc_d = resp_pc_q + 64'd4;
            end
            if (resp_ok && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_entry
        // PC and instruction storage for queue entry gi
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == AW'(gi))) begin
                q_pc[gi]   <= push_pc;
                q_inst[gi] <= push_inst;
            end
        end
    end

`ifndef SYNTHESIS
    // Responses may only arrive for requests that are actually outstanding
    always_ff @(posedge clk) begin
        if (!rst && imem_rvalid) begin
            assert (inflight_q != '0)
            else $error("inst_fetch_unit: imem_rvalid with no request in flight");
        end
    end
`endif

endmodule
